// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared definitions for the load/store unit: FSM state
//                encoding, RV32I load/store size codes, the default
//                memory-ack timeout and a funct3 legality helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // Default number of BUSY cycles to wait for mem_ack before giving up.
    localparam int unsigned c_default_timeout = 255;

    // FSM state encoding.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    // RV32I load/store size/sign codes.
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    // Stores only know B/H/W; loads additionally know the unsigned forms.
    function automatic logic funct3_supported(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == c_f3_b) || (f3 == c_f3_h) || (f3 == c_f3_w);
        end
        return (f3 == c_f3_b) || (f3 == c_f3_h) || (f3 == c_f3_w) ||
               (f3 == c_f3_bu) || (f3 == c_f3_hu);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Purely combinational lane logic for the load/store unit.
//                Decides access legality (size code + alignment), produces
//                byte enables and lane-replicated store data, and extracts /
//                extends the addressed byte or halfword of a read word.
//  Ports       : i_we, i_funct3, i_addr_lo  - access description
//                i_wdata                    - raw store data
//                i_rdata                    - raw read word from memory
//                o_legal                    - access is supported and aligned
//                o_be, o_wdata              - memory byte enables / store lanes
//                o_load_ext                 - extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
)(
    input  logic          i_we,
    input  logic [2:0]    i_funct3,
    input  logic [1:0]    i_addr_lo,
    input  logic [DW-1:0] i_wdata,
    input  logic [DW-1:0] i_rdata,
    output logic          o_legal,
    output logic [3:0]    o_be,
    output logic [DW-1:0] o_wdata,
    output logic [DW-1:0] o_load_ext
);

    logic          w_misaligned;
    logic [DW-1:0] w_shifted;

    // funct3[1:0] carries the access size for both loads and stores.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b01:   w_misaligned = i_addr_lo[0];
            2'b10:   w_misaligned = (i_addr_lo != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        o_legal = funct3_supported(i_we, i_funct3) && !w_misaligned;
    end

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_we) begin
            case (i_funct3[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {(DW/8){i_wdata[7:0]}};
                end
                2'b01: begin
                    o_be    = 4'b0011 << i_addr_lo;
                    o_wdata = {(DW/16){i_wdata[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

    always_comb begin
        o_load_ext = i_rdata;
        case (i_funct3)
            c_f3_b:  o_load_ext = {{(DW-8){w_shifted[7]}},   w_shifted[7:0]};
            c_f3_h:  o_load_ext = {{(DW-16){w_shifted[15]}}, w_shifted[15:0]};
            c_f3_bu: o_load_ext = {{(DW-8){1'b0}},           w_shifted[7:0]};
            c_f3_hu: o_load_ext = {{(DW-16){1'b0}},          w_shifted[15:0]};
            default: o_load_ext = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : RV32I load/store unit with a simple req/ack memory port.
//                IDLE accepts a legal access (or pulses fault), BUSY holds
//                the memory request until ack or timeout, DONE presents the
//                load result for one cycle and returns to IDLE.
//  Ports       : clk, rst (async, active-low)
//                req_valid, req_we, funct3, addr, wdata - pipeline request
//                stall, load_data, load_valid, fault, timeout - to pipeline
//                mem_req, mem_we, mem_addr, mem_be, mem_wdata - to memory
//                mem_ack, mem_rdata - from memory
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = c_default_timeout,
    parameter int DW      = 32
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    funct3,
    input  logic [DW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          stall,
    output logic [DW-1:0] load_data,
    output logic          load_valid,
    output logic          fault,
    output logic          timeout,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    // The counter only needs to reach TIMEOUT-1 (the last BUSY cycle).
    localparam int              c_cnt_w    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    logic [1:0]         r_state;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [DW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [c_cnt_w-1:0] r_cnt;
    logic [DW-1:0]      r_load_data;
    logic               r_load_valid;
    logic               r_fault;
    logic               r_timeout;

    logic               w_idle;
    logic               w_busy;
    logic               w_sel_we;
    logic [2:0]         w_sel_funct3;
    logic [1:0]         w_sel_addr_lo;
    logic [DW-1:0]      w_sel_wdata;
    logic               w_legal;
    logic [3:0]         w_be;
    logic [DW-1:0]      w_lane_wdata;
    logic [DW-1:0]      w_load_ext;

    assign w_idle = (r_state == c_st_idle);
    assign w_busy = (r_state == c_st_busy);

    // One align instance serves both phases: in IDLE it judges the incoming
    // request, afterwards it works from the captured request so memory-side
    // outputs stay stable for the whole BUSY period.
    assign w_sel_we      = w_idle ? req_we     : r_we;
    assign w_sel_funct3  = w_idle ? funct3     : r_funct3;
    assign w_sel_addr_lo = w_idle ? addr[1:0]  : r_addr[1:0];
    assign w_sel_wdata   = w_idle ? wdata      : r_wdata;

    lsu_align #(
        .DW (DW)
    ) u_align (
        .i_we       (w_sel_we),
        .i_funct3   (w_sel_funct3),
        .i_addr_lo  (w_sel_addr_lo),
        .i_wdata    (w_sel_wdata),
        .i_rdata    (mem_rdata),
        .o_legal    (w_legal),
        .o_be       (w_be),
        .o_wdata    (w_lane_wdata),
        .o_load_ext (w_load_ext)
    );

    assign stall      = (w_idle && req_valid && w_legal) || w_busy;
    assign mem_req    = w_busy;
    assign mem_we     = w_busy && r_we;
    assign mem_addr   = w_busy ? {r_addr[DW-1:2], 2'b00} : '0;
    assign mem_be     = w_busy ? w_be : 4'b0000;
    assign mem_wdata  = (w_busy && r_we) ? w_lane_wdata : '0;
    assign load_data  = r_load_data;
    assign load_valid = r_load_valid;
    assign fault      = r_fault;
    assign timeout    = r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_we         <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_load_data  <= '0;
            r_load_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_fault      <= 1'b0;
            r_timeout    <= 1'b0;
            r_load_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        if (w_legal) begin
                            r_we     <= req_we;
                            r_funct3 <= funct3;
                            r_addr   <= addr;
                            r_wdata  <= wdata;
                            r_cnt    <= '0;
                            r_state  <= c_st_busy;
                        end else begin
                            r_fault  <= 1'b1;
                        end
                    end
                end
                c_st_busy: begin
                    // An ack on the final counted cycle still wins over timeout.
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_load_data <= w_load_ext;
                        end
                        r_load_valid <= !r_we;
                        r_state      <= c_st_done;
                    end else if (r_cnt == c_cnt_last) begin
                        r_timeout    <= 1'b1;
                        r_load_data  <= '0;
                        r_load_valid <= !r_we;
                        r_state      <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit. A table of directed
//                load/store vectors with hand-computed results is replayed
//                through a transaction task; reset, reset-during-BUSY and a
//                back-to-back store/load are written out as explicit
//                sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [2:0]    funct3 = 3'b000;
    logic [DW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          stall;
    logic [DW-1:0] load_data;
    logic          load_valid;
    logic          fault;
    logic          timeout;
    logic          mem_req;
    logic          mem_we;
    logic [DW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT (TMO),
        .DW      (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .fault      (fault),
        .timeout    (timeout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;   // ack in BUSY cycle ack_dly+1; -1 = never
        logic        e_fault;
        int          e_busy;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        logic        e_to;
    } vec_t;

    typedef struct {
        logic        stall_req;
        logic        fault;
        logic        fault2;
        int          busy;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        stable;
        logic        stall_busy;
        logic        stall_done;
        logic        lv;
        logic [31:0] ld;
        logic        to;
        logic        lv2;
        logic [31:0] ld2;
    } obs_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                       input int dly, input logic ef, input int eb, input logic [31:0] ea,
                       input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld,
                       input logic eto);
        vec_t v;
        v.name = name; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.ack_dly = dly; v.e_fault = ef; v.e_busy = eb; v.e_addr = ea; v.e_be = ebe;
        v.e_wdata = ewd; v.e_ld = eld; v.e_to = eto;
        vecs.push_back(v);
    endtask

    // Drives one request starting in IDLE and records what the DUT did.
    task automatic run_txn(input vec_t v, output obs_t o);
        int busy;
        bit done;
        o = '{default: '0};
        o.stable     = 1'b1;
        o.stall_busy = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1 o.stall_req = stall;
        @(negedge clk);
        req_valid = 1'b0;
        #1 o.fault = fault;
        busy = 0;
        done = 1'b0;
        while (!done) begin
            if (mem_req === 1'b1) begin
                busy++;
                if (busy == 1) begin
                    o.we = mem_we; o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata;
                end else if (mem_we !== o.we || mem_addr !== o.addr ||
                             mem_be !== o.be || mem_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                if (stall !== 1'b1) o.stall_busy = 1'b0;
                if (busy - 1 == v.ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end
                @(negedge clk);
                mem_ack = 1'b0; mem_rdata = '0;
                #1;
                if (busy > 20) done = 1'b1;
            end else begin
                o.lv = load_valid; o.ld = load_data; o.to = timeout; o.stall_done = stall;
                done = 1'b1;
            end
        end
        o.busy = busy;
        @(negedge clk);
        #1;
        o.fault2 = fault; o.lv2 = load_valid; o.ld2 = load_data;
    endtask

    logic [31:0] mem_word;

    initial begin
        obs_t o;

        // name       we  f3      addr        wdata         rdata         dly f  busy e_addr       be      e_wdata       e_ld          to
        add("lb_neg",   0, 3'b000, 32'h103,    32'h0,        32'h80FF_0000, 1, 0, 2, 32'h100, 4'b1111, 32'h0,        32'hFFFF_FF80, 0);
        add("sh_hi",    1, 3'b001, 32'h202,    32'h0000_ABCD, 32'h0,        0, 0, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0,        0);
        add("lw_mis",   0, 3'b010, 32'h105,    32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("lhu_tmo",  0, 3'b101, 32'h0,      32'h0,        32'h0,        -1, 0, 4, 32'h0,   4'b1111, 32'h0,        32'h0,        1);
        add("sb_l3",    1, 3'b000, 32'h13,     32'h1234_56A5, 32'h0,        0, 0, 1, 32'h10,  4'b1000, 32'hA5A5_A5A5, 32'h0,        0);
        add("sb_l1",    1, 3'b000, 32'h31,     32'h0000_0077, 32'h0,        2, 0, 3, 32'h30,  4'b0010, 32'h7777_7777, 32'h0,        0);
        add("lh_hi",    0, 3'b001, 32'h2,      32'h0,        32'h8001_1234, 2, 0, 3, 32'h0,   4'b1111, 32'h0,        32'hFFFF_8001, 0);
        add("lbu_l1",   0, 3'b100, 32'h101,    32'h0,        32'h1122_8344, 0, 0, 1, 32'h100, 4'b1111, 32'h0,        32'h0000_0083, 0);
        add("lhu_hi",   0, 3'b101, 32'h2,      32'h0,        32'hF00D_0000, 1, 0, 2, 32'h0,   4'b1111, 32'h0,        32'h0000_F00D, 0);
        add("lw_lastc", 0, 3'b010, 32'h8,      32'h0,        32'hDEAD_BEEF, 3, 0, 4, 32'h8,   4'b1111, 32'h0,        32'hDEAD_BEEF, 0);
        add("lb_pos",   0, 3'b000, 32'h0,      32'h0,        32'h1234_567F, 0, 0, 1, 32'h0,   4'b1111, 32'h0,        32'h0000_007F, 0);
        add("sw",       1, 3'b010, 32'h40,     32'hCAFE_BABE, 32'h0,        1, 0, 2, 32'h40,  4'b1111, 32'hCAFE_BABE, 32'h0,        0);
        add("sh_lo",    1, 3'b001, 32'h0,      32'hFFFF_1234, 32'h0,        0, 0, 1, 32'h0,   4'b0011, 32'h1234_1234, 32'h0,        0);
        add("lh_mis",   0, 3'b001, 32'h1,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("ld_f011",  0, 3'b011, 32'h0,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("ld_f110",  0, 3'b110, 32'h0,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("ld_f111",  0, 3'b111, 32'h0,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("st_f100",  1, 3'b100, 32'h0,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("st_f011",  1, 3'b011, 32'h0,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("sw_mis",   1, 3'b010, 32'h2,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("sh_mis",   1, 3'b001, 32'h3,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);
        add("lhu_mis",  0, 3'b101, 32'h1,      32'h0,        32'h0,         0, 1, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        0);

        // ---- reset state ----
        @(negedge clk);
        #1;
        check("rst mem_req",    32'(mem_req),    32'h0);
        check("rst stall",      32'(stall),      32'h0);
        check("rst load_valid", 32'(load_valid), 32'h0);
        check("rst load_data",  load_data,       32'h0);
        check("rst fault",      32'(fault),      32'h0);
        check("rst timeout",    32'(timeout),    32'h0);
        check("rst mem_be",     32'(mem_be),     32'h0);
        check("rst mem_addr",   mem_addr,        32'h0);
        check("rst mem_wdata",  mem_wdata,       32'h0);
        check("rst mem_we",     32'(mem_we),     32'h0);
        @(negedge clk);
        rst = 1'b1;

        // ---- table-driven vectors ----
        foreach (vecs[i]) begin
            run_txn(vecs[i], o);
            check({vecs[i].name, " fault"},       32'(o.fault),     32'(vecs[i].e_fault));
            check({vecs[i].name, " fault_clr"},   32'(o.fault2),    32'h0);
            check({vecs[i].name, " stall_req"},   32'(o.stall_req), 32'(!vecs[i].e_fault));
            check({vecs[i].name, " busy_cycles"}, 32'(o.busy),      32'(vecs[i].e_busy));
            if (!vecs[i].e_fault) begin
                check({vecs[i].name, " mem_we"},     32'(o.we),         32'(vecs[i].we));
                check({vecs[i].name, " mem_addr"},   o.addr,            vecs[i].e_addr);
                check({vecs[i].name, " mem_be"},     32'(o.be),         32'(vecs[i].e_be));
                check({vecs[i].name, " mem_wdata"},  o.wdata,           vecs[i].e_wdata);
                check({vecs[i].name, " stable"},     32'(o.stable),     32'h1);
                check({vecs[i].name, " stall_busy"}, 32'(o.stall_busy), 32'h1);
                check({vecs[i].name, " stall_done"}, 32'(o.stall_done), 32'h0);
                check({vecs[i].name, " timeout"},    32'(o.to),         32'(vecs[i].e_to));
                check({vecs[i].name, " load_valid"}, 32'(o.lv),         32'(!vecs[i].we));
                check({vecs[i].name, " lv_clr"},     32'(o.lv2),        32'h0);
                if (!vecs[i].we) begin
                    check({vecs[i].name, " load_data"}, o.ld,  vecs[i].e_ld);
                    check({vecs[i].name, " ld_hold"},   o.ld2, vecs[i].e_ld);
                end
            end
        end

        // ---- reset asserted during BUSY, late ack afterwards ----
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("rstbusy mem_req_pre", 32'(mem_req), 32'h1);
        rst = 1'b0;
        #1;
        check("rstbusy mem_req", 32'(mem_req), 32'h0);
        check("rstbusy stall",   32'(stall),   32'h0);
        check("rstbusy mem_be",  32'(mem_be),  32'h0);
        @(negedge clk);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("rstbusy late_ack lv",      32'(load_valid), 32'h0);
        check("rstbusy late_ack mem_req", 32'(mem_req),    32'h0);
        @(negedge clk);
        #1;
        check("rstbusy idle lv",   32'(load_valid), 32'h0);
        check("rstbusy idle ld",   load_data,       32'h0);
        check("rstbusy idle req",  32'(mem_req),    32'h0);

        // ---- back-to-back SW then LW at 0x10, ack with mem_req ----
        mem_word = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; funct3 = 3'b010; addr = 32'h10; wdata = 32'h1357_9BDF;
        @(negedge clk);
        req_valid = 1'b0;
        #1 check("b2b sw mem_req", 32'(mem_req), 32'h1);
        for (int b = 0; b < 4; b++) begin
            if (mem_req && mem_we && mem_be[b]) mem_word[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        // DONE: hold the LW request here; it must be taken only after IDLE.
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h10;
        #1;
        check("b2b done mem_req", 32'(mem_req), 32'h0);
        check("b2b done stall",   32'(stall),   32'h0);
        @(negedge clk);
        #1;
        check("b2b idle stall",   32'(stall),   32'h1);
        check("b2b idle mem_req", 32'(mem_req), 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("b2b lw mem_req",  32'(mem_req), 32'h1);
        check("b2b lw mem_addr", mem_addr,      32'h10);
        mem_ack = 1'b1; mem_rdata = mem_word;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("b2b lw load_valid", 32'(load_valid), 32'h1);
        check("b2b lw load_data",  load_data,       32'h1357_9BDF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of BUSY cycles to wait for mem_ack.
REQ-002 SHALL have parameter DW, default 32: data and address width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: current instruction is a load or store.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port funct3, input, 3: RV32I size/sign code; 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port addr, input, DW: effective byte address from the EX ALUOut.
REQ-009 SHALL have port wdata, input, DW: store data from register-file ReadData2.
REQ-010 SHALL have port stall, output, 1: holds PC and register writeback.
REQ-011 SHALL have port load_data, output, DW: extended load result for WB.
REQ-012 SHALL have port load_valid, output, 1: load_data is valid this cycle.
REQ-013 SHALL have port fault, output, 1: one-cycle pulse on misaligned access or illegal funct3.
REQ-014 SHALL have port timeout, output, 1: one-cycle pulse when TIMEOUT expires.
REQ-015 SHALL have port mem_req, output, 1: memory request, held until ack.
REQ-016 SHALL have port mem_we, output, 1: memory write enable.
REQ-017 SHALL have port mem_addr, output, DW: word address; bits [1:0] are always 00.
REQ-018 SHALL have port mem_be, output, 4: byte enables.
REQ-019 SHALL have port mem_wdata, output, DW: lane-replicated store data.
REQ-020 SHALL have port mem_ack, input, 1: memory completion for the current request.
REQ-021 SHALL have port mem_rdata, input, DW: read word, valid together with mem_ack.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-023 IDLE transitions:
- req_valid=1 and access legal: register we/funct3/addr/wdata, go to BUSY.
- req_valid=1 and access illegal: pulse fault, stay in IDLE, no mem_req.
REQ-024 Illegal access is any of:
- H/HU/SH with addr[0]=1;
- W/SW with addr[1:0]!=00;
- load funct3 in {011, 110, 111};
- store funct3 > 010.
REQ-025 stall SHALL be combinational: 1 in IDLE when req_valid=1 and the access is legal, 1 in BUSY, 0 otherwise.
REQ-026 mem_req SHALL be 1 in BUSY only, with mem_addr/mem_we/mem_be/mem_wdata stable for the whole BUSY period.
REQ-027 In BUSY, mem_ack=1 SHALL capture the extended mem_rdata (loads) and transition to DONE; an ack in the first BUSY cycle is legal, giving a minimum latency of 2 cycles from acceptance to DONE.
REQ-028 DONE SHALL assert load_valid=1 for loads only, hold stall=0, and return to IDLE unconditionally after one cycle.
REQ-029 A BUSY cycle counter SHALL reach TIMEOUT without ack → pulse timeout, set load_data=0, go to DONE.
REQ-030 Store lanes:
- SB: mem_be = 0001<<addr[1:0], byte replicated ×4;
- SH: mem_be = 0011<<addr[1:0], halfword replicated ×2;
- SW: mem_be = 1111, data unchanged.
REQ-031 Loads SHALL select the byte/halfword addressed by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-032 Loads SHALL drive mem_be=1111 and mem_we=0.
REQ-033 mem_ack outside BUSY SHALL be ignored; load_data SHALL hold its last value outside DONE.

Reset
REQ-034 rst=0 SHALL immediately force the state to IDLE, clear the counter, and set all outputs to 0 (mem_req deasserted combinationally from state).
REQ-035 rst asserted during BUSY SHALL abandon the request; a late mem_ack after release SHALL be ignored.

Structure
REQ-036 Package lsu_pkg SHALL hold the state encoding, funct3 constants and the default TIMEOUT.
REQ-037 Sub-module lsu_align (combinational) SHALL compute legality, mem_be, mem_wdata and load extension; the FSM stays in load_store_unit.

Verification
REQ-038 LB at addr 0x103, mem_rdata 0x80FF_0000 with ack 1 cycle after mem_req → mem_addr 0x100, load_data 0xFFFF_FF80, load_valid for 1 cycle.
REQ-039 SH at 0x202, wdata 0x0000_ABCD → mem_be 1100, mem_wdata 0xABCD_ABCD, mem_we=1, stall=1 until DONE.
REQ-040 LW at 0x105 → fault pulse, no mem_req, stall=0.
REQ-041 LHU at 0x0 with no ack, TIMEOUT=4 → 4 BUSY cycles, timeout pulse, load_data 0.
REQ-042 rst=0 asserted during BUSY → mem_req=0 in the same cycle; ack after release is ignored and state stays IDLE.
REQ-043 Back-to-back SW then LW at 0x10 with ack in the same cycle as mem_req → the LW returns the stored word; DONE→IDLE→BUSY sequence observed.
